// File: rtl/mac_accum_ctrl.sv
// Accumulation controller for a low-voltage adder: feeds products into an external
// adder, replays sums flagged by the timing-error detector, and hands out the total.
module mac_accum_ctrl #(
    parameter int LEN_W     = 8,
    parameter int MAX_RETRY = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [LEN_W-1:0]        len,
    input  logic                    p_valid,
    input  logic signed [15:0]      p_data,
    output logic                    p_ready,
    output logic signed [15:0]      add_a,
    output logic signed [23:0]      add_b,
    input  logic signed [23:0]      add_z,
    input  logic                    add_err,
    output logic                    res_valid,
    output logic signed [23:0]      res_data,
    input  logic                    res_ready,
    output logic                    res_err,
    output logic [7:0]              replay_cnt,
    output logic                    busy
);

    localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    typedef enum logic [1:0] {IDLE, ACC, REPLAY, DONE} state_t;

    state_t                    state_q, state_d;
    logic signed [23:0]        acc_q, acc_d;
    logic signed [15:0]        hold_q, hold_d;
    logic [LEN_W-1:0]          count_q, count_d;
    logic [LEN_W-1:0]          len_q, len_d;
    logic [RETRY_W-1:0]        retry_q, retry_d;
    logic [7:0]                replay_q, replay_d;
    logic                      err_q, err_d;
    logic [LEN_W-1:0]          count_inc;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign count_inc  = count_q + LEN_W'(1);
    assign add_b      = acc_q;
    assign res_data   = acc_q;
    assign res_err    = err_q;
    assign replay_cnt = replay_q;
    assign busy       = (state_q != IDLE);

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        hold_d    = hold_q;
        count_d   = count_q;
        len_d     = len_q;
        retry_d   = retry_q;
        replay_d  = replay_q;
        err_d     = err_q;
        p_ready   = 1'b0;
        res_valid = 1'b0;
        add_a     = p_data;
        case (state_q)
            IDLE: begin
                if (start) begin
                    len_d    = len;
                    acc_d    = '0;
                    count_d  = '0;
                    retry_d  = '0;
                    replay_d = '0;
                    err_d    = 1'b0;
                    state_d  = (len == '0) ? DONE : ACC;
                end
            end
            ACC: begin
                p_ready = 1'b1;
                if (p_valid) begin
                    if (!add_err) begin
                        acc_d   = add_z;
                        count_d = count_inc;
                        state_d = (count_inc == len_q) ? DONE : ACC;
                    end else begin
                        hold_d   = p_data;
                        retry_d  = RETRY_W'(1);
                        replay_d = sat_inc8(replay_q);
                        state_d  = REPLAY;
                    end
                end
            end
            REPLAY: begin
                add_a = hold_q;
                // Once the retry budget is spent the flagged sum is taken anyway and marked.
                if (!add_err || (retry_q >= RETRY_W'(MAX_RETRY))) begin
                    if (add_err) begin
                        err_d = 1'b1;
                    end
                    acc_d   = add_z;
                    count_d = count_inc;
                    state_d = (count_inc == len_q) ? DONE : ACC;
                end else begin
                    retry_d  = retry_q + RETRY_W'(1);
                    replay_d = sat_inc8(replay_q);
                end
            end
            DONE: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            hold_q   <= '0;
            count_q  <= '0;
            len_q    <= '0;
            retry_q  <= '0;
            replay_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            hold_q   <= hold_d;
            count_q  <= count_d;
            len_q    <= len_d;
            retry_q  <= retry_d;
            replay_q <= replay_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_mac_accum_ctrl.sv
// Randomized bench for mac_accum_ctrl with an ideal adder and a per-job reference model.
module tb_mac_accum_ctrl;

    localparam int MAXR = 3;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [7:0]         len;
    logic               p_valid;
    logic signed [15:0] p_data;
    logic               p_ready;
    logic signed [15:0] add_a;
    logic signed [23:0] add_b;
    logic signed [23:0] add_z;
    logic               add_err;
    logic               res_valid;
    logic signed [23:0] res_data;
    logic               res_ready;
    logic               res_err;
    logic [7:0]         replay_cnt;
    logic               busy;

    int checks = 0;
    int failures = 0;

    logic [15:0] prods [0:127];
    int          errs  [0:127];

    mac_accum_ctrl #(.LEN_W(8), .MAX_RETRY(MAXR)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .p_valid(p_valid), .p_data(p_data), .p_ready(p_ready),
        .add_a(add_a), .add_b(add_b), .add_z(add_z), .add_err(add_err),
        .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
        .res_err(res_err), .replay_cnt(replay_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    // Ideal adder: b plus sign-extended a, wrapping at 24 bits.
    assign add_z = add_b + {{8{add_a[15]}}, add_a};

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached (checks=%0d)", checks);
        $fatal(1, "watchdog");
    end

    // Whole-job expectation: total sum, replays clipped per product and overall, sticky error.
    function automatic void model(input int n, output logic [23:0] s, output int rc, output bit er);
        s = '0;
        rc = 0;
        er = 1'b0;
        for (int i = 0; i < n; i++) begin
            s = s + {{8{prods[i][15]}}, prods[i]};
            rc = rc + ((errs[i] > MAXR) ? MAXR : errs[i]);
            if (errs[i] > MAXR) er = 1'b1;
        end
        if (rc > 255) rc = 255;
    endfunction

    task automatic run_job(input int n, input int gap_max, input int bp, input bit noisy);
        logic [23:0] esum;
        logic [23:0] part;
        logic [23:0] held;
        int          erc;
        bit          eerr;
        int          nrep;
        int          gaps;
        model(n, esum, erc, eerr);
        part = '0;
        @(negedge clk);
        start = 1'b1; len = 8'(n); p_valid = 1'b0; res_ready = 1'b0; add_err = 1'b0;
        @(posedge clk);
        for (int i = 0; i < n; i++) begin
            gaps = $urandom_range(0, gap_max);
            for (int g = 0; g < gaps; g++) begin
                @(negedge clk);
                start = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
                len = 8'($urandom); p_valid = 1'b0; p_data = 16'($urandom);
                add_err = 1'($urandom_range(0, 1));
                #1;
                checks++;
                if (p_ready !== 1'b1 || res_valid !== 1'b0 || busy !== 1'b1 || add_b !== part) begin
                    failures++;
                    $display("FAIL idle_wait: p_ready=%b res_valid=%b busy=%b add_b=%h required 1 0 1 %h",
                             p_ready, res_valid, busy, add_b, part);
                end
                @(posedge clk);
            end
            nrep = (errs[i] > MAXR) ? MAXR : errs[i];
            for (int k = 0; k <= nrep; k++) begin
                @(negedge clk);
                start = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
                len = 8'($urandom);
                p_valid = 1'b1;
                p_data = (k == 0) ? prods[i] : 16'($urandom);
                add_err = (k < errs[i]);
                #1;
                checks++;
                if (p_ready !== (k == 0) || add_a !== prods[i] || add_b !== part || res_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL attempt p%0d k%0d: p_ready=%b add_a=%h add_b=%h res_valid=%b required %b %h %h 0",
                             i, k, p_ready, add_a, add_b, res_valid, (k == 0), prods[i], part);
                end
                @(posedge clk);
            end
            part = part + {{8{prods[i][15]}}, prods[i]};
        end
        @(negedge clk);
        p_valid = 1'b0;
        start = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
        #1;
        checks++;
        if (res_valid !== 1'b1 || res_data !== esum || replay_cnt !== 8'(erc) || res_err !== eerr || p_ready !== 1'b0) begin
            failures++;
            $display("FAIL result n=%0d: valid=%b data=%h rc=%0d err=%b p_ready=%b required 1 %h %0d %b 0",
                     n, res_valid, res_data, replay_cnt, res_err, p_ready, esum, erc, eerr);
        end
        held = res_data;
        for (int b = 0; b < bp; b++) begin
            @(negedge clk);
            start = noisy ? (b % 2 == 0) : 1'b0;
            len = 8'($urandom);
            #1;
            checks++;
            if (res_valid !== 1'b1 || res_data !== esum || res_data !== held) begin
                failures++;
                $display("FAIL backpressure b%0d: valid=%b data=%h required 1 %h", b, res_valid, res_data, esum);
            end
        end
        @(negedge clk);
        res_ready = 1'b1;
        start = noisy;
        @(negedge clk);
        res_ready = 1'b0;
        start = 1'b0;
        #1;
        checks++;
        if (res_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL drain: res_valid=%b busy=%b required 0 0", res_valid, busy);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; len = '0; p_valid = 1'b0; p_data = '0;
        add_err = 1'b0; res_ready = 1'b0;
        #3;
        checks++;
        if (busy !== 1'b0 || p_ready !== 1'b0 || res_valid !== 1'b0 || res_data !== 24'h0 ||
            res_err !== 1'b0 || replay_cnt !== 8'h0 || add_b !== 24'h0) begin
            failures++;
            $display("FAIL reset_state: busy=%b p_ready=%b res_valid=%b res_data=%h res_err=%b rc=%h required all zero",
                     busy, p_ready, res_valid, res_data, res_err, replay_cnt);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic;
        prods[0] = 16'hF234; errs[0] = 0;
        prods[1] = 16'h0010; errs[1] = 0;
        run_job(2, 0, 0, 1'b0);
    endtask

    task automatic test_single_replay;
        prods[0] = 16'h0005; errs[0] = 1;
        run_job(1, 0, 0, 1'b0);
    endtask

    task automatic test_retry_exhaust;
        prods[0] = 16'h0007; errs[0] = 9;
        run_job(1, 0, 0, 1'b0);
    endtask

    task automatic test_zero_len;
        run_job(0, 0, 0, 1'b0);
    endtask

    task automatic test_backpressure;
        prods[0] = 16'h8001; errs[0] = 0;
        prods[1] = 16'h1234; errs[1] = 2;
        run_job(2, 1, 5, 1'b1);
    endtask

    task automatic test_reset_mid_job;
        @(negedge clk);
        start = 1'b1; len = 8'd4; p_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            p_valid = 1'b1; p_data = 16'h0100 + 16'(i); add_err = 1'b0;
            @(negedge clk);
        end
        p_data = 16'h0777;
        #2 rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || p_ready !== 1'b0 || res_valid !== 1'b0 || res_data !== 24'h0 ||
            res_err !== 1'b0 || replay_cnt !== 8'h0 || add_b !== 24'h0) begin
            failures++;
            $display("FAIL async_reset: busy=%b p_ready=%b res_valid=%b res_data=%h required all zero",
                     busy, p_ready, res_valid, res_data);
        end
        @(negedge clk);
        rst = 1'b0; p_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (res_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL abandoned_job: res_valid=%b busy=%b required 0 0", res_valid, busy);
        end
        prods[0] = 16'h0001; errs[0] = 0;
        run_job(1, 0, 0, 1'b0);
    endtask

    task automatic test_replay_saturation;
        for (int i = 0; i < 90; i++) begin
            prods[i] = 16'($urandom);
            errs[i] = MAXR;
        end
        run_job(90, 0, 0, 1'b0);
    endtask

    task automatic test_random;
        int r;
        for (int j = 0; j < 25; j++) begin
            int n;
            n = $urandom_range(0, 6);
            for (int i = 0; i < n; i++) begin
                prods[i] = 16'($urandom);
                r = $urandom_range(0, 9);
                errs[i] = (r < 5) ? 0 : (r < 8) ? int'($urandom_range(1, MAXR)) : int'($urandom_range(MAXR + 1, MAXR + 3));
            end
            run_job(n, 2, $urandom_range(0, 3), 1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_single_replay();
        test_retry_exhaust();
        test_zero_len();
        test_backpressure();
        test_reset_mid_job();
        test_replay_saturation();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mac_accum_ctrl.md
MAC_ACCUM_CTRL -- requirements
Module: mac_accum_ctrl

Interface
REQ-001 The block SHALL have parameter LEN_W, default 8, giving the width of the product-count field.
REQ-002 The block SHALL have parameter MAX_RETRY, default 3, giving the maximum replays per product.
REQ-003 The block SHALL use a single clock, clk; reset is asynchronous and active-high, rst.
REQ-004 Ports SHALL be:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start  in  1  begin an accumulation
- len  in  LEN_W  number of products to accumulate
- p_valid  in  1  product available
- p_data  in  16  signed product
- p_ready  out  1  product accepted when p_valid&p_ready
- add_a  out  16  adder operand a
- add_b  out  24  adder operand b (accumulator)
- add_z  in  24  adder sum, combinational from add_a/add_b
- add_err  in  1  low-voltage timing-error flag for add_z, same cycle
- res_valid  out  1  result available
- res_data  out  24  accumulated result
- res_ready  in  1  result consumed when res_valid&res_ready
- res_err  out  1  sticky: a sum was accepted with add_err high
- replay_cnt  out  8  saturating count of replays in current job
- busy  out  1  state != IDLE

Function
REQ-005 The FSM SHALL have states IDLE, ACC, REPLAY and DONE.
REQ-006 In IDLE, start=1 SHALL latch len, clear acc, the count, replay_cnt, res_err and the retry counter, and go to ACC, or to DONE if len=0.
REQ-007 start SHALL be ignored in every state other than IDLE.
REQ-008 Operand muxing SHALL be combinational: add_a = hold register in REPLAY, else p_data; add_b = acc at all times.
REQ-009 p_ready SHALL be 1 only in ACC.
REQ-010 On an ACC handshake with add_err=0, the block SHALL set acc <= add_z and count++; when count reaches len it SHALL go to DONE, else stay in ACC.
REQ-011 On an ACC handshake with add_err=1, the block SHALL set hold <= p_data, leave acc unchanged, set retry=1, increment replay_cnt, and go to REPLAY.
REQ-012 In REPLAY with add_err=0, the block SHALL set acc <= add_z and count++, then go to ACC, or to DONE if count reaches len.
REQ-013 In REPLAY with add_err=1 and retry<MAX_RETRY, the block SHALL increment retry and replay_cnt and stay in REPLAY.
REQ-014 In REPLAY with add_err=1 and retry=MAX_RETRY, the block SHALL accept add_z anyway, set res_err=1, and continue as in REQ-012.
REQ-015 The block SHALL NOT modify the adder's arithmetic; sums wrap mod 2^24, and no overflow detection is performed.
REQ-016 In DONE, res_valid SHALL be 1 and res_data SHALL equal acc, both stable until res_ready=1; on that handshake the block SHALL go to IDLE and drop res_valid the next cycle.
REQ-017 res_valid SHALL rise the cycle after the final sum is accepted; each product costs 1 cycle plus 1 cycle per replay.
REQ-018 replay_cnt SHALL saturate at 8'hFF.
REQ-019 p_valid without a handshake SHALL cause no state change.

Reset
REQ-020 While rst=1, regardless of clk: state=IDLE; acc, hold, count, retry, replay_cnt, res_data=0; res_valid, res_err, p_ready, busy=0.
REQ-021 Reset asserted mid-job SHALL abandon the job; no result is emitted.

Verification
Bench adder model: z = b + sign-extended a, mod 2^24.
REQ-022 Basic: len=2, products 16'hF234 then 16'h0010, add_err=0 -> two p_ready handshakes, res_valid 1 cycle after the second; res_data=24'hFFF244, res_err=0, replay_cnt=0.
REQ-023 Single replay: len=1, p_data=16'h0005, add_err=1 for the first cycle only -> p_ready=0 for 1 cycle, res_data=24'h000005, replay_cnt=1, res_err=0.
REQ-024 Retry exhaustion: len=1, p_data=16'h0007, add_err held high -> 3 REPLAY cycles, sum accepted on the 3rd; res_data=24'h000007, replay_cnt=3, res_err=1.
REQ-025 Zero length: start with len=0 -> res_valid=1 the cycle after start, res_data=0, no p_ready pulse.
REQ-026 Backpressure and reset: res_ready=0 for 5 cycles -> res_data stable and a start pulse ignored; separately, rst pulsed mid-ACC with len=4 after 2 products -> all outputs zero immediately, and a new start (len=1, 16'h0001) yields 24'h000001.
